// File: rtl/codec_cfg_seq.sv
// Power-up codec register loader over I2C, driving a bit-level driver.
// Define CODEC_CFG_RETRY_EN to retry an entry up to MAX_RETRY times after a NACK.
module codec_cfg_seq #(
    parameter int         NUM_REGS  = 11,
    parameter int         IDX_W     = 4,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         TIMEOUT   = 255,
    parameter int         MAX_RETRY = 2
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_word,
    output logic             i2c_start,
    output logic             i2c_stop,
    output logic             i2c_write,
    output logic [7:0]       i2c_data,
    input  logic             i2c_cmd_done,
    input  logic             i2c_cmd_status
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

`ifdef CODEC_CFG_RETRY_EN
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);
    logic [RT_W-1:0] retries;
`endif

    typedef enum logic [3:0] {
        IDLE, RECOV, START, ADDR, REGHI, REGLO,
        STOP, FSTOP, GAP, DONE, FAIL
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [WD_W-1:0] wdog;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            nxt       <= IDLE;
            wdog      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            tbl_index <= '0;
            i2c_start <= 1'b0;
            i2c_stop  <= 1'b0;
            i2c_write <= 1'b0;
            i2c_data  <= '0;
`ifdef CODEC_CFG_RETRY_EN
            retries   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        tbl_index <= '0;
                        wdog      <= '0;
                        i2c_stop  <= 1'b1;
                        state     <= RECOV;
`ifdef CODEC_CFG_RETRY_EN
                        retries   <= '0;
`endif
                    end
                end
                RECOV, START, ADDR, REGHI, REGLO, STOP, FSTOP: begin
                    if (i2c_cmd_done) begin
                        i2c_start <= 1'b0;
                        i2c_stop  <= 1'b0;
                        i2c_write <= 1'b0;
                        wdog      <= '0;
                        state     <= GAP;
                        case (state)
                            RECOV: nxt <= START;
                            START: nxt <= ADDR;
                            ADDR:  nxt <= i2c_cmd_status ? REGHI : FSTOP;
                            REGHI: nxt <= i2c_cmd_status ? REGLO : FSTOP;
                            REGLO: nxt <= i2c_cmd_status ? STOP : FSTOP;
                            STOP: begin
                                if (tbl_index == LAST_IDX) begin
                                    nxt <= DONE;
                                end else begin
                                    nxt       <= START;
                                    tbl_index <= tbl_index + 1'b1;
`ifdef CODEC_CFG_RETRY_EN
                                    retries   <= '0;
`endif
                                end
                            end
                            FSTOP: begin
`ifdef CODEC_CFG_RETRY_EN
                                if (retries < RT_MAX) begin
                                    retries <= retries + 1'b1;
                                    nxt     <= START;
                                end else begin
                                    err_index <= tbl_index;
                                    nxt       <= FAIL;
                                end
`else
                                err_index <= tbl_index;
                                nxt       <= FAIL;
`endif
                            end
                            default: nxt <= IDLE;
                        endcase
                    end else if (wdog == WD_LAST) begin
                        // Driver never answered: abandon the run.
                        i2c_start <= 1'b0;
                        i2c_stop  <= 1'b0;
                        i2c_write <= 1'b0;
                        wdog      <= '0;
                        err_index <= tbl_index;
                        state     <= FAIL;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                GAP: begin
                    state <= nxt;
                    unique case (nxt)
                        START: i2c_start <= 1'b1;
                        STOP, FSTOP: i2c_stop <= 1'b1;
                        ADDR: begin
                            i2c_write <= 1'b1;
                            i2c_data  <= {DEV_ADDR, 1'b0};
                        end
                        REGHI: begin
                            i2c_write <= 1'b1;
                            i2c_data  <= tbl_word[15:8];
                        end
                        REGLO: begin
                            i2c_write <= 1'b1;
                            i2c_data  <= tbl_word[7:0];
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                FAIL: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Randomized bench for codec_cfg_seq with a driver model and command-level reference.
// Expectations follow CODEC_CFG_RETRY_EN when it is defined.
module tb_codec_cfg_seq;

    localparam int NR   = 3;
    localparam int MAXR = 2;
`ifdef CODEC_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        busy, done, error;
    logic [3:0]  err_index, tbl_index;
    logic [15:0] tbl_word;
    logic        i2c_start, i2c_stop, i2c_write;
    logic [7:0]  i2c_data;
    logic        i2c_cmd_done = 1'b0;
    logic        i2c_cmd_status = 1'b0;

    logic [15:0] tbl [16];
    assign tbl_word = tbl[tbl_index];

    codec_cfg_seq #(
        .NUM_REGS(NR), .IDX_W(4), .DEV_ADDR(7'h1A),
        .TIMEOUT(255), .MAX_RETRY(MAXR)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .go(go),
        .busy(busy), .done(done), .error(error),
        .err_index(err_index), .tbl_index(tbl_index),
        .tbl_word(tbl_word),
        .i2c_start(i2c_start), .i2c_stop(i2c_stop),
        .i2c_write(i2c_write), .i2c_data(i2c_data),
        .i2c_cmd_done(i2c_cmd_done),
        .i2c_cmd_status(i2c_cmd_status)
    );

    always #5 sys_clk = ~sys_clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int enc(input int t, input int d);
        return t * 256 + d;
    endfunction

    // Reference: expected command list, write statuses and outcome.
    int nk [NR][MAXR+1];
    int exp_q[$];
    bit st_q[$];
    bit x_fail;
    int x_idx;

    task automatic build_model(input int hang);
        int wn;
        int att;
        int k;
        bit adv;
        logic [7:0] by [3];
        exp_q.delete();
        st_q.delete();
        x_fail = 0;
        x_idx = 0;
        wn = 0;
        exp_q.push_back(enc(1, 0));
        for (int e = 0; e < NR && !x_fail; e++) begin
            att = 0;
            adv = 0;
            by[0] = 8'h34;
            by[1] = tbl[e][15:8];
            by[2] = tbl[e][7:0];
            while (!adv && !x_fail) begin
                k = nk[e][att];
                exp_q.push_back(enc(0, 0));
                for (int b = 0; b < 3; b++) begin
                    exp_q.push_back(enc(2, int'(by[b])));
                    if (wn == hang) begin
                        x_fail = 1;
                        x_idx = e;
                        break;
                    end
                    wn++;
                    st_q.push_back(b != k);
                    if (b == k) break;
                end
                if (x_fail) break;
                exp_q.push_back(enc(1, 0));
                if (k >= 3) adv = 1;
                else if (RETRY && att < MAXR) att++;
                else begin
                    x_fail = 1;
                    x_idx = e;
                end
            end
        end
    endtask

    // Bus monitor and driver model share one negedge process.
    int  obs[$];
    bit  clr_req = 0;
    int  hang_wr = -1;
    int  excl_err = 0, stab_err = 0, gap_err = 0;
    int  hi_len = 0;

    initial begin
        bit pany = 0, pw = 0, had_cmd = 0, serving = 0, hang_now = 0, pend = 1;
        logic [7:0] pdata = 0;
        logic [2:0] s;
        int low_len = 0, hi_cur = 0, dly = 0, wr_cnt = 0;
        forever begin
            @(negedge sys_clk);
            if (clr_req) begin
                obs.delete();
                had_cmd = 0;
                wr_cnt = 0;
                clr_req = 0;
            end
            s = {i2c_start, i2c_stop, i2c_write};
            if ($countones(s) > 1) excl_err++;
            if (i2c_write && pw && i2c_data != pdata) stab_err++;
            if (|s && !pany) begin
                if (had_cmd && low_len != 1) gap_err++;
                had_cmd = 1;
                hi_cur = 0;
                obs.push_back(i2c_write ? enc(2, int'(i2c_data)) :
                              i2c_start ? enc(0, 0) : enc(1, 0));
            end
            if (|s) begin
                hi_cur++;
                low_len = 0;
            end else begin
                if (pany) hi_len = hi_cur;
                low_len++;
            end
            pany = |s;
            pw = i2c_write;
            pdata = i2c_data;
            if (i2c_cmd_done) begin
                i2c_cmd_done = 0;
                serving = 0;
            end else if (!(|s)) begin
                serving = 0;
            end else begin
                if (!serving) begin
                    serving = 1;
                    dly = $urandom_range(0, 3);
                    hang_now = 0;
                    pend = 1;
                    if (i2c_write) begin
                        hang_now = (wr_cnt == hang_wr);
                        wr_cnt++;
                        if (!hang_now && st_q.size() > 0) pend = st_q.pop_front();
                    end
                end
                if (!hang_now) begin
                    if (dly == 0) begin
                        i2c_cmd_done = 1;
                        i2c_cmd_status = pend;
                    end else dly--;
                end
            end
        end
    end

    task automatic plan_ack();
        for (int e = 0; e < NR; e++)
            for (int a = 0; a <= MAXR; a++) nk[e][a] = 3;
    endtask

    task automatic rand_tbl();
        for (int i = 0; i < 16; i++) tbl[i] = 16'($urandom);
    endtask

    task automatic start_run(input int hang);
        build_model(hang);
        hang_wr = hang;
        excl_err = 0;
        stab_err = 0;
        gap_err = 0;
        @(negedge sys_clk);
        clr_req = 1;
        go = 1;
        @(negedge sys_clk);
        go = 0;
    endtask

    task automatic run(input int hang, input string nm);
        int mism;
        start_run(hang);
        repeat (2) @(negedge sys_clk);
        chk({nm, "_busy"}, busy, 1);
        go = 1;
        @(negedge sys_clk);
        go = 0;
        for (int i = 0; i < 20000 && busy; i++) @(negedge sys_clk);
        chk({nm, "_ended"}, busy, 0);
        repeat (2) @(negedge sys_clk);
        chk({nm, "_done"}, done, !x_fail);
        chk({nm, "_error"}, error, x_fail);
        if (x_fail) chk({nm, "_err_index"}, err_index, x_idx);
        mism = (obs.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i] != exp_q[i]) mism++;
        chk({nm, "_seq"}, mism, 0);
        chk({nm, "_excl"}, excl_err, 0);
        chk({nm, "_stable"}, stab_err, 0);
        chk({nm, "_gap"}, gap_err, 0);
    endtask

    initial begin
        rand_tbl();
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_tbl_index", tbl_index, 0);
        chk("rst_strobes", {i2c_start, i2c_stop, i2c_write}, 0);
        chk("rst_data", i2c_data, 0);
        rst = 0;

        tbl[1] = 16'h1E00;
        plan_ack();
        run(-1, "ack");
        if (obs.size() >= 10) begin
            chk("byte_addr", obs[7], enc(2, 8'h34));
            chk("byte_1e", obs[8], enc(2, 8'h1E));
            chk("byte_00", obs[9], enc(2, 8'h00));
        end else chk("ack_obs_len", obs.size(), 16);

        plan_ack();
        for (int a = 0; a <= MAXR; a++) nk[2][a] = 1;
        run(-1, "nack_e2");

        plan_ack();
        nk[0][0] = 0; nk[0][1] = 2; nk[0][2] = 3;
        run(-1, "nack2_ok");

        plan_ack();
        nk[0][0] = 1; nk[0][1] = 0; nk[0][2] = 2;
        run(-1, "nack3");

        for (int r = 0; r < 6; r++) begin
            rand_tbl();
            for (int e = 0; e < NR; e++)
                for (int a = 0; a <= MAXR; a++)
                    nk[e][a] = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(0, 2);
            run(-1, $sformatf("rnd%0d", r));
        end

        plan_ack();
        run(0, "tmo");
        chk("tmo_len", hi_len, 255);

        plan_ack();
        start_run(5);
        for (int i = 0; i < 2000 && obs.size() < 10; i++) @(negedge sys_clk);
        chk("rst_reached", obs.size(), 10);
        if (obs.size() >= 10) chk("rst_reglo", obs[9], enc(2, int'(tbl[1][7:0])));
        repeat (3) @(negedge sys_clk);
        rst = 1;
        @(negedge sys_clk);
        chk("midrst_strobes", {i2c_start, i2c_stop, i2c_write}, 0);
        chk("midrst_busy", busy, 0);
        rst = 0;
        plan_ack();
        run(-1, "after_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
